except_ctrl: RTL and testbench
==============================

Name: except_ctrl

Overview:
- MEM-stage exception arbiter: takes per-instruction exception flags and hardware interrupt lines, resolves a single exception, and drives the CP0 register file's excepttype/current-instruction/delay-slot inputs.
- Same-cycle CP0 state is forwarded from WB writes (status/cause/epc).
- Generates the pipeline flush pulse and redirect PC (handler or EPC).
- Supplies synchronised interrupt lines to CP0.

Parameters:
- FLUSH_CYCLES, 1: cycles flush_o stays high per taken exception (1..15).
- HANDLER_OFFSET, 32'h00000180: offset added to ebase for non-eret exceptions.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-low
- except_flags_i  in  32  MEM flags: bit8 syscall, bit9 invalid inst, bit11 overflow, bit12 eret; other bits ignored
- inst_valid_i  in  1  MEM slot holds a real instruction (not a bubble)
- current_inst_addr_i  in  32  PC of the MEM instruction
- is_in_delayslot_i  in  1  MEM instruction is in a delay slot
- cp0_status_i  in  32  CP0 status
- cp0_cause_i  in  32  CP0 cause
- cp0_epc_i  in  32  CP0 epc
- cp0_ebase_i  in  32  CP0 ebase
- wb_cp0_we_i  in  1  WB writes CP0 this cycle
- wb_cp0_waddr_i  in  5  WB CP0 write address
- wb_cp0_data_i  in  32  WB CP0 write data
- int_i  in  6  raw hardware interrupt lines
- timer_int_i  in  1  CP0 timer interrupt
- excepttype_o  out  32  to CP0: 0, 1 int, 8 syscall, a invalid, c overflow, e eret
- current_inst_addr_o  out  32  to CP0
- is_in_delayslot_o  out  1  to CP0
- cp0_int_o  out  6  synchronised interrupt lines to CP0
- flush_o  out  1  flush all pipeline registers
- new_pc_o  out  32  redirect target, valid while flush_o=1

Behaviour:
- Reset (rst=0, async): excepttype_o=0, current_inst_addr_o=0, is_in_delayslot_o=0, flush_o=0, new_pc_o=0, cp0_int_o=0, synchroniser flops=0, state=IDLE, counter=0.
- Forwarding, combinational:
  - status_f = wb data if wb_cp0_we_i and waddr=12, else cp0_status_i.
  - epc_f = wb data if waddr=14, else cp0_epc_i.
  - cause_f = cp0_cause_i with bits 9:8, 23, 22 taken from wb data if waddr=13.
- Interrupt pending: {cp0_int_o[5]|timer_int_i, cp0_int_o[4:0], cause_f[9:8]} & status_f[15:8] != 0, and status_f[0]=1, and status_f[1]=0.
- Priority, only when inst_valid_i=1: interrupt (1) > syscall (8) > invalid (a) > overflow (c) > eret (e). None set gives code 0.
- States: IDLE, FLUSH.
- IDLE, resolved code nonzero at edge N:
  - At N+1: excepttype_o=code, current_inst_addr_o and is_in_delayslot_o captured, flush_o=1.
  - new_pc_o = epc_f for eret; otherwise cp0_ebase_i + HANDLER_OFFSET (32-bit wrap).
  - Counter loads FLUSH_CYCLES-1. Go to FLUSH if FLUSH_CYCLES>1, else stay IDLE.
- IDLE, code 0: excepttype_o=0, flush_o=0.
- FLUSH:
  - excepttype_o=0 from the second cycle on, so CP0 records exactly once.
  - flush_o=1 and new_pc_o held. Counter decrements; at 0, return to IDLE with flush_o=0 next cycle.
  - All inputs ignored (exceptions and interrupts are not taken).
- Latency: one cycle from detection to outputs. An exception is never lost in IDLE.
- Back-to-back in IDLE with FLUSH_CYCLES=1: a new exception on the cycle after flush is accepted normally.
- Reset asserted mid-FLUSH clears all state immediately. flush_o drops without waiting for the clock.

Optional Feature:
- EXC_INT_SYNC_EN defined: int_i passes through a 2-flop synchroniser; cp0_int_o lags int_i by 2 cycles.
- Undefined: cp0_int_o registered once from int_i (1-cycle lag); int_i must already be synchronous to clk.

Test Plan:
- Syscall, no delay slot:
  - Stimulus: flags=0x100, valid=1, pc=0x80001000, ebase=0x80000000.
  - Next cycle: excepttype_o=8, current_inst_addr_o=0x80001000, flush_o=1, new_pc_o=0x80000180.
  - Following cycle: excepttype_o=0.
- Eret with WB forwarding:
  - Stimulus: flags=0x1000; same cycle wb_cp0_we_i=1, waddr=14, data=0x80002004; cp0_epc_i=0.
  - Response: excepttype_o=e, new_pc_o=0x80002004.
- Interrupt priority over overflow:
  - Stimulus: status=0x0000FC01, int_i=6'b000001 held past the synchroniser lag, flags=0x800, pc=0x80000010, delay slot=1.
  - Response: excepttype_o=1, is_in_delayslot_o=1.
  - Repeat with status[1]=1: excepttype_o=c.
- Bubble gating:
  - Stimulus: inst_valid_i=0, flags=0x200.
  - Response: excepttype_o=0, flush_o=0.
- FLUSH_CYCLES=3:
  - Stimulus: syscall, then an overflow flag on the next 2 cycles.
  - Response: flush_o high exactly 3 cycles, excepttype_o=8 only in the first; overflow ignored.
- Async reset mid-flush:
  - Stimulus: drop rst between clock edges during FLUSH.
  - Response: flush_o=0 and excepttype_o=0 immediately; after release, IDLE.

Source files
------------

// File: rtl/except_ctrl.sv
//------------------------------------------------------------------------------
// except_ctrl -- MEM-stage exception arbiter
//
// Purpose:
//   Resolves one exception per instruction from the MEM-stage flags and the
//   pending hardware/software interrupts. It then drives the CP0 register
//   file's excepttype / current-instruction / delay-slot inputs, and raises a
//   pipeline flush pulse together with the redirect PC (handler or EPC).
//   CP0 status/cause/epc values written by WB in the same cycle are forwarded,
//   so the decision always uses the newest architectural state.
//
// Parameters:
//   FLUSH_CYCLES   : cycles flush_o stays high per taken exception (1..15)
//   HANDLER_OFFSET : offset added to ebase for every exception except eret
//
// Optional feature (macro EXC_INT_SYNC_EN):
//   defined   : int_i goes through a 2-flop synchroniser (cp0_int_o lags 2)
//   undefined : int_i is registered once (cp0_int_o lags 1); int_i must
//               already be synchronous to clk
//
// Ports:
//   clk                 in   system clock
//   rst                 in   asynchronous active-low reset
//   except_flags_i      in   [8] syscall, [9] invalid, [11] overflow, [12] eret
//   inst_valid_i        in   MEM slot holds a real instruction
//   current_inst_addr_i in   PC of the MEM instruction
//   is_in_delayslot_i   in   MEM instruction is in a delay slot
//   cp0_status_i        in   CP0 status
//   cp0_cause_i         in   CP0 cause
//   cp0_epc_i           in   CP0 epc
//   cp0_ebase_i         in   CP0 ebase
//   wb_cp0_we_i         in   WB writes CP0 this cycle
//   wb_cp0_waddr_i      in   WB CP0 write address
//   wb_cp0_data_i       in   WB CP0 write data
//   int_i               in   raw hardware interrupt lines
//   timer_int_i         in   CP0 timer interrupt
//   excepttype_o        out  0 none, 1 int, 8 syscall, a invalid, c ovf, e eret
//   current_inst_addr_o out  faulting PC to CP0
//   is_in_delayslot_o   out  delay-slot flag to CP0
//   cp0_int_o           out  synchronised interrupt lines to CP0
//   flush_o             out  flush all pipeline registers
//   new_pc_o            out  redirect target, valid while flush_o=1
//------------------------------------------------------------------------------
module except_ctrl #(
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter logic [31:0] HANDLER_OFFSET = 32'h00000180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] except_flags_i,
  input  logic        inst_valid_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic [31:0] cp0_ebase_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  input  logic [5:0]  int_i,
  input  logic        timer_int_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [5:0]  cp0_int_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  // CP0 register addresses observed on the WB write port
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // Cause bits that software (or the interrupt logic) may write: IP[1:0], 23, 22
  localparam logic [31:0] CAUSE_WMASK = 32'h00C00300;

  // Exception codes delivered to CP0
  localparam logic [31:0] EXC_NONE = 32'h00000000;
  localparam logic [31:0] EXC_INT  = 32'h00000001;
  localparam logic [31:0] EXC_SYS  = 32'h00000008;
  localparam logic [31:0] EXC_INV  = 32'h0000000A;
  localparam logic [31:0] EXC_OV   = 32'h0000000C;
  localparam logic [31:0] EXC_ERET = 32'h0000000E;

  // Counter preload; with a single flush cycle the FSM never leaves IDLE
  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam bit         GO_FLUSH = (FLUSH_CYCLES > 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [31:0] r_excepttype;
  logic [31:0] w_excepttype_nxt;
  logic [31:0] r_inst_addr;
  logic [31:0] w_inst_addr_nxt;
  logic        r_delayslot;
  logic        w_delayslot_nxt;
  logic        r_flush;
  logic        w_flush_nxt;
  logic [31:0] r_new_pc;
  logic [31:0] w_new_pc_nxt;
  logic [5:0]  r_cp0_int;

  logic [31:0] w_status_f;
  logic [31:0] w_cause_f;
  logic [31:0] w_epc_f;
  logic [7:0]  w_int_src;
  logic        w_int_pend;
  logic [31:0] w_code;
  logic [31:0] w_handler_pc;

  // Forward a same-cycle WB write so the arbiter never acts on stale CP0 state
  assign w_status_f = (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_STATUS)) ?
                      wb_cp0_data_i : cp0_status_i;
  assign w_epc_f    = (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_EPC)) ?
                      wb_cp0_data_i : cp0_epc_i;
  assign w_cause_f  = (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_CAUSE)) ?
                      ((cp0_cause_i & ~CAUSE_WMASK) | (wb_cp0_data_i & CAUSE_WMASK)) :
                      cp0_cause_i;

  // Interrupt sources line up with status IM[7:0]; the timer shares line 5
  assign w_int_src  = {r_cp0_int[5] | timer_int_i, r_cp0_int[4:0], w_cause_f[9:8]};
  // Taken only with IE=1 and EXL=0
  assign w_int_pend = (|(w_int_src & w_status_f[15:8])) &&
                      w_status_f[0] && !w_status_f[1];

  assign w_handler_pc = cp0_ebase_i + HANDLER_OFFSET;

  // Fixed-priority resolution; a bubble never raises an exception
  always_comb begin
    w_code = EXC_NONE;
    if (!inst_valid_i) begin
      w_code = EXC_NONE;
    end else if (w_int_pend) begin
      w_code = EXC_INT;
    end else if (except_flags_i[8]) begin
      w_code = EXC_SYS;
    end else if (except_flags_i[9]) begin
      w_code = EXC_INV;
    end else if (except_flags_i[11]) begin
      w_code = EXC_OV;
    end else if (except_flags_i[12]) begin
      w_code = EXC_ERET;
    end else begin
      w_code = EXC_NONE;
    end
  end

  // Next-state and next-output logic of the IDLE/FLUSH controller
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_excepttype_nxt = r_excepttype;
    w_inst_addr_nxt  = r_inst_addr;
    w_delayslot_nxt  = r_delayslot;
    w_flush_nxt      = r_flush;
    w_new_pc_nxt     = r_new_pc;
    case (r_state)
      ST_IDLE: begin
        if (w_code != EXC_NONE) begin
          w_excepttype_nxt = w_code;
          w_inst_addr_nxt  = current_inst_addr_i;
          w_delayslot_nxt  = is_in_delayslot_i;
          w_flush_nxt      = 1'b1;
          w_new_pc_nxt     = (w_code == EXC_ERET) ? w_epc_f : w_handler_pc;
          w_cnt_nxt        = CNT_LOAD;
          w_state_nxt      = GO_FLUSH ? ST_FLUSH : ST_IDLE;
        end else begin
          w_excepttype_nxt = EXC_NONE;
          w_flush_nxt      = 1'b0;
        end
      end
      ST_FLUSH: begin
        // CP0 must record the exception only once, so the code is cleared
        // while the flush and redirect PC are held; inputs are ignored here.
        w_excepttype_nxt = EXC_NONE;
        w_flush_nxt      = 1'b1;
        w_cnt_nxt        = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_FLUSH;
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_cnt_nxt        = 4'd0;
        w_excepttype_nxt = EXC_NONE;
        w_flush_nxt      = 1'b0;
      end
    endcase
  end

  // Controller state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_excepttype <= EXC_NONE;
      r_inst_addr  <= 32'h00000000;
      r_delayslot  <= 1'b0;
      r_flush      <= 1'b0;
      r_new_pc     <= 32'h00000000;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_excepttype <= w_excepttype_nxt;
      r_inst_addr  <= w_inst_addr_nxt;
      r_delayslot  <= w_delayslot_nxt;
      r_flush      <= w_flush_nxt;
      r_new_pc     <= w_new_pc_nxt;
    end
  end

`ifdef EXC_INT_SYNC_EN
  logic [5:0] r_int_meta;

  // Two-flop synchroniser for asynchronous interrupt lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_int_meta <= 6'd0;
      r_cp0_int  <= 6'd0;
    end else begin
      r_int_meta <= int_i;
      r_cp0_int  <= r_int_meta;
    end
  end
`else
  // Single register stage; int_i is already synchronous to clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cp0_int <= 6'd0;
    end else begin
      r_cp0_int <= int_i;
    end
  end
`endif

  assign excepttype_o        = r_excepttype;
  assign current_inst_addr_o = r_inst_addr;
  assign is_in_delayslot_o   = r_delayslot;
  assign cp0_int_o           = r_cp0_int;
  assign flush_o             = r_flush;
  assign new_pc_o            = r_new_pc;

endmodule

// File: tb/tb_except_ctrl.sv
//------------------------------------------------------------------------------
// tb_except_ctrl -- self-checking bench for except_ctrl
//
// dut1 (FLUSH_CYCLES=1): reset values, directed vector table, interrupt
// priority sequence and randomized stimulus against a reference model.
// dut3 (FLUSH_CYCLES=3): multi-cycle flush and asynchronous reset mid-flush.
//------------------------------------------------------------------------------
module tb_except_ctrl;

`ifdef EXC_INT_SYNC_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 1;
`endif

  logic        clk = 1'b0;
  logic        rst1 = 1'b0;
  logic        rst3 = 1'b0;
  logic [31:0] flags = '0, pc = '0, status = '0, cause = '0, epc = '0, ebase = '0;
  logic [31:0] wdata = '0;
  logic        valid = 1'b0, ds = 1'b0, we = 1'b0, timer = 1'b0;
  logic [4:0]  waddr = '0;
  logic [5:0]  int_i = '0;

  logic [31:0] et1, addr1, npc1, et3, addr3, npc3;
  logic        ds1, fl1, ds3, fl3;
  logic [5:0]  ci1, ci3;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state: interrupt lines as CP0 currently sees them
  logic [5:0] m_q[$];
  logic [5:0] m_int;

  always #5 clk = ~clk;

  except_ctrl #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .except_flags_i(flags), .inst_valid_i(valid),
    .current_inst_addr_i(pc), .is_in_delayslot_i(ds), .cp0_status_i(status),
    .cp0_cause_i(cause), .cp0_epc_i(epc), .cp0_ebase_i(ebase),
    .wb_cp0_we_i(we), .wb_cp0_waddr_i(waddr), .wb_cp0_data_i(wdata),
    .int_i(int_i), .timer_int_i(timer), .excepttype_o(et1),
    .current_inst_addr_o(addr1), .is_in_delayslot_o(ds1), .cp0_int_o(ci1),
    .flush_o(fl1), .new_pc_o(npc1));

  except_ctrl #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .except_flags_i(flags), .inst_valid_i(valid),
    .current_inst_addr_i(pc), .is_in_delayslot_i(ds), .cp0_status_i(status),
    .cp0_cause_i(cause), .cp0_epc_i(epc), .cp0_ebase_i(ebase),
    .wb_cp0_we_i(we), .wb_cp0_waddr_i(waddr), .wb_cp0_data_i(wdata),
    .int_i(int_i), .timer_int_i(timer), .excepttype_o(et3),
    .current_inst_addr_o(addr3), .is_in_delayslot_o(ds3), .cp0_int_o(ci3),
    .flush_o(fl3), .new_pc_o(npc3));

  typedef struct {
    logic [31:0] flags;
    logic        valid;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] ebase;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        timer;
    logic [31:0] exp_et;
    logic [31:0] exp_npc;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Exception code from the architectural rules, using model interrupt lines
  function automatic logic [31:0] model_code();
    logic [31:0] sf, cf;
    logic pend, src;
    sf = (we && waddr == 5'd12) ? wdata : status;
    cf = cause;
    if (we && waddr == 5'd13) cf = (cause & ~32'h00C00300) | (wdata & 32'h00C00300);
    pend = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k < 2)      src = cf[8 + k];
      else if (k < 7) src = m_int[k - 2];
      else            src = m_int[5] | timer;
      if (src && sf[8 + k]) pend = 1'b1;
    end
    if (!valid)                  return 32'h0;
    if (pend && sf[0] && !sf[1]) return 32'h1;
    if (flags[8])                return 32'h8;
    if (flags[9])                return 32'hA;
    if (flags[11])               return 32'hC;
    if (flags[12])               return 32'hE;
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_npc(input logic [31:0] code);
    if (code == 32'hE) return (we && waddr == 5'd14) ? wdata : epc;
    return ebase + 32'h180;
  endfunction

  task automatic model_reset();
    m_q = {};
    for (int i = 0; i < LAG - 1; i++) m_q.push_back(6'd0);
    m_int = 6'd0;
  endtask

  // One dut1 cycle: model predicts from present inputs, then clock advances
  task automatic cyc1(output logic [31:0] e_et, output logic [31:0] e_npc);
    e_et  = model_code();
    e_npc = model_npc(e_et);
    @(posedge clk); #1;
    m_q.push_back(int_i);
    m_int = m_q.pop_front();
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic zero_inputs();
    flags = '0; valid = 1'b0; pc = '0; ds = 1'b0; status = '0; cause = '0;
    epc = '0; ebase = '0; we = 1'b0; waddr = '0; wdata = '0; timer = 1'b0; int_i = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] e_et, e_npc;

    //            flags         v     pc            ds    status        cause         epc           ebase         we    wa     wdata         tmr   exp_et  exp_npc
    tv[0]  = '{32'h00000100, 1'b1, 32'h80001000, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h80000000, 1'b0, 5'd0,  32'h00000000, 1'b0, 32'h8, 32'h80000180};
    tv[1]  = '{32'h00001000, 1'b1, 32'h80001004, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h80000000, 1'b1, 5'd14, 32'h80002004, 1'b0, 32'hE, 32'h80002004};
    tv[2]  = '{32'h00000200, 1'b0, 32'h80001008, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h80000000, 1'b0, 5'd0,  32'h00000000, 1'b0, 32'h0, 32'h00000000};
    tv[3]  = '{32'h00000200, 1'b1, 32'h8000100C, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFF00, 1'b0, 5'd0,  32'h00000000, 1'b0, 32'hA, 32'h00000080};
    tv[4]  = '{32'h00001800, 1'b1, 32'h80001010, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h80000000, 1'b0, 5'd0,  32'h00000000, 1'b0, 32'hC, 32'h80000180};
    tv[5]  = '{32'h00000300, 1'b1, 32'h80001014, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h80000000, 1'b0, 5'd0,  32'h00000000, 1'b0, 32'h8, 32'h80000180};
    tv[6]  = '{32'hFFFFE4FF, 1'b1, 32'h80001018, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h80000000, 1'b0, 5'd0,  32'h00000000, 1'b0, 32'h0, 32'h00000000};
    tv[7]  = '{32'h00000000, 1'b1, 32'h8000101C, 1'b0, 32'h00000101, 32'h00000000, 32'h00000000, 32'h80000000, 1'b1, 5'd13, 32'h00000100, 1'b0, 32'h1, 32'h80000180};
    tv[8]  = '{32'h00000000, 1'b1, 32'h80001020, 1'b0, 32'h00000000, 32'h00000100, 32'h00000000, 32'h80000000, 1'b1, 5'd12, 32'h00000101, 1'b0, 32'h1, 32'h80000180};
    tv[9]  = '{32'h00000800, 1'b1, 32'h80001024, 1'b0, 32'h00000103, 32'h00000100, 32'h00000000, 32'h80000000, 1'b0, 5'd0,  32'h00000000, 1'b0, 32'hC, 32'h80000180};
    tv[10] = '{32'h00000000, 1'b1, 32'h80001028, 1'b0, 32'h00000100, 32'h00000100, 32'h00000000, 32'h80000000, 1'b0, 5'd0,  32'h00000000, 1'b0, 32'h0, 32'h00000000};
    tv[11] = '{32'h00000000, 1'b1, 32'h8000102C, 1'b0, 32'h00008001, 32'h00000000, 32'h00000000, 32'h80000000, 1'b0, 5'd0,  32'h00000000, 1'b1, 32'h1, 32'h80000180};
    tv[12] = '{32'h00001000, 1'b1, 32'h80001030, 1'b0, 32'h00000001, 32'h00000100, 32'h00001234, 32'h80000000, 1'b1, 5'd12, 32'h00000000, 1'b0, 32'hE, 32'h00001234};

    // reset values
    zero_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_type", et1, 32'h0);
    chk("rst_addr", addr1, 32'h0);
    chk("rst_ds", {31'd0, ds1}, 32'h0);
    chk("rst_flush", {31'd0, fl1}, 32'h0);
    chk("rst_npc", npc1, 32'h0);
    chk("rst_cp0int", {26'd0, ci1}, 32'h0);
    rst1 = 1'b1;
    model_reset();

    // directed vector table, applied back to back
    for (int i = 0; i < 13; i++) begin
      flags = tv[i].flags; valid = tv[i].valid; pc = tv[i].pc; ds = tv[i].ds;
      status = tv[i].status; cause = tv[i].cause; epc = tv[i].epc; ebase = tv[i].ebase;
      we = tv[i].we; waddr = tv[i].waddr; wdata = tv[i].wdata; timer = tv[i].timer;
      cyc1(e_et, e_npc);
      chk($sformatf("vec%0d_type", i), et1, tv[i].exp_et);
      chk($sformatf("vec%0d_flush", i), {31'd0, fl1}, {31'd0, tv[i].exp_et != 32'h0});
      if (tv[i].exp_et != 32'h0) begin
        chk($sformatf("vec%0d_npc", i), npc1, tv[i].exp_npc);
        chk($sformatf("vec%0d_addr", i), addr1, tv[i].pc);
        chk($sformatf("vec%0d_ds", i), {31'd0, ds1}, {31'd0, tv[i].ds});
      end
    end

    // hardware interrupt beats overflow, then is masked by EXL
    zero_inputs();
    status = 32'h0000FC01; int_i = 6'b000001; ebase = 32'h80000000;
    repeat (3) cyc1(e_et, e_npc);
    chk("int_cp0int", {26'd0, ci1}, 32'h1);
    chk("int_bubble_type", et1, 32'h0);
    flags = 32'h00000800; valid = 1'b1; pc = 32'h80000010; ds = 1'b1;
    cyc1(e_et, e_npc);
    chk("int_prio_type", et1, 32'h1);
    chk("int_prio_ds", {31'd0, ds1}, 32'h1);
    chk("int_prio_addr", addr1, 32'h80000010);
    chk("int_prio_flush", {31'd0, fl1}, 32'h1);
    status = 32'h0000FC03;
    cyc1(e_et, e_npc);
    chk("int_exl_type", et1, 32'hC);
    zero_inputs();

    // randomized stimulus against the model
    for (int i = 0; i < 400; i++) begin
      flags  = ($urandom & 32'hFFFFE4FF) | (($urandom_range(0, 1) == 1) ? ($urandom & 32'h00001B00) : 32'h0);
      valid  = ($urandom_range(0, 3) != 0);
      pc     = $urandom; ds = $urandom_range(0, 1);
      status = $urandom & 32'hFFFFFF03; cause = $urandom;
      epc    = $urandom; ebase = $urandom;
      we     = $urandom_range(0, 1); waddr = 5'($urandom_range(11, 15)); wdata = $urandom;
      int_i  = 6'($urandom); timer = ($urandom_range(0, 7) == 0);
      cyc1(e_et, e_npc);
      chk($sformatf("rnd%0d_type", i), et1, e_et);
      chk($sformatf("rnd%0d_flush", i), {31'd0, fl1}, {31'd0, e_et != 32'h0});
      chk($sformatf("rnd%0d_cp0int", i), {26'd0, ci1}, {26'd0, m_int});
      if (e_et != 32'h0) begin
        chk($sformatf("rnd%0d_npc", i), npc1, e_npc);
        chk($sformatf("rnd%0d_addr", i), addr1, pc);
        chk($sformatf("rnd%0d_ds", i), {31'd0, ds1}, {31'd0, ds});
      end
    end

    // FLUSH_CYCLES=3: flush held three cycles, code once, overflow ignored
    zero_inputs();
    rst3 = 1'b1;
    repeat (2) step();
    chk("f3_idle_flush", {31'd0, fl3}, 32'h0);
    flags = 32'h00000100; valid = 1'b1; pc = 32'h80003000; ebase = 32'h80000000;
    step();
    chk("f3_c1_type", et3, 32'h8);
    chk("f3_c1_flush", {31'd0, fl3}, 32'h1);
    chk("f3_c1_npc", npc3, 32'h80000180);
    chk("f3_c1_addr", addr3, 32'h80003000);
    flags = 32'h00000800;
    step();
    chk("f3_c2_type", et3, 32'h0);
    chk("f3_c2_flush", {31'd0, fl3}, 32'h1);
    chk("f3_c2_npc", npc3, 32'h80000180);
    step();
    chk("f3_c3_type", et3, 32'h0);
    chk("f3_c3_flush", {31'd0, fl3}, 32'h1);
    flags = 32'h0;
    step();
    chk("f3_c4_type", et3, 32'h0);
    chk("f3_c4_flush", {31'd0, fl3}, 32'h0);

    // asynchronous reset between edges while flushing
    flags = 32'h00000100;
    step();
    chk("ar_pre_flush", {31'd0, fl3}, 32'h1);
    flags = 32'h0;
    #2 rst3 = 1'b0;
    #1;
    chk("ar_flush", {31'd0, fl3}, 32'h0);
    chk("ar_type", et3, 32'h0);
    chk("ar_npc", npc3, 32'h0);
    @(negedge clk) rst3 = 1'b1;
    step();
    chk("ar_post_flush", {31'd0, fl3}, 32'h0);
    flags = 32'h00000200; valid = 1'b1; pc = 32'h80004000;
    step();
    chk("ar_idle_type", et3, 32'hA);
    chk("ar_idle_flush", {31'd0, fl3}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
